// File: rtl/weight_dispatch_seq.sv
`default_nettype none
// ============================================================================
// Module   : weight_dispatch_seq
// Purpose  : Fetches weight words one at a time from the BRAM controller,
//            buffers them in a 2-entry FIFO and hands them to the MAC array.
// Revision : 1.0
// ============================================================================
module weight_dispatch_seq #(
  parameter int MAC_NUM     = 256,
  parameter int WEIGHT_BITS = 5,
  parameter int CNT_WIDTH   = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_WIDTH-1:0]           word_total,
  output logic                           fetch_req,
  input  logic [WEIGHT_BITS*MAC_NUM-1:0] weight_in,
  input  logic                           weight_in_valid,
  output logic [WEIGHT_BITS*MAC_NUM-1:0] mac_weight,
  output logic                           mac_valid,
  input  logic                           mac_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           err_unexpected
);

  localparam int c_word_w = WEIGHT_BITS * MAC_NUM;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_total;
  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_delivered;
  logic                 r_fetch_req;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic [c_word_w-1:0]  r_mem [0:1];
  logic                 r_wptr;
  logic                 r_rptr;
  logic [1:0]           r_count;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_mac_valid;
  logic [CNT_WIDTH-1:0] w_delivered_next;
  logic                 w_last_hs;

  assign w_mac_valid      = (r_count != 2'd0);
  assign w_push           = (r_state == ST_WAIT) && weight_in_valid;
  assign w_pop            = w_mac_valid && mac_ready;
  assign w_delivered_next = r_delivered + CNT_WIDTH'(w_pop);
  // True when the layer is fully consumed as of this edge, so done can follow
  // the final handshake by exactly one cycle.
  assign w_last_hs        = (w_delivered_next == r_total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_total     <= '0;
      r_issued    <= '0;
      r_delivered <= '0;
      r_fetch_req <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_fetch_req <= 1'b0;
      r_done      <= 1'b0;
      if (weight_in_valid && (r_state != ST_WAIT)) begin
        r_err <= 1'b1;
      end
      if (w_pop) begin
        r_delivered <= w_delivered_next;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (word_total != '0) begin
              r_total     <= word_total;
              r_issued    <= '0;
              r_delivered <= '0;
              r_busy      <= 1'b1;
              r_fetch_req <= 1'b1;
              r_state     <= ST_REQ;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          r_issued <= r_issued + CNT_WIDTH'(1);
          r_state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (weight_in_valid) begin
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_issued == r_total) begin
            if (w_last_hs) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else if (r_count < 2'd2) begin
            r_fetch_req <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (w_last_hs) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Storage needs no reset: occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= weight_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_wptr <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign fetch_req      = r_fetch_req;
  assign busy           = r_busy;
  assign done           = r_done;
  assign err_unexpected = r_err;
  assign mac_valid      = w_mac_valid;
  assign mac_weight     = w_mac_valid ? r_mem[r_rptr] : '0;

endmodule
`default_nettype wire
